// File: rtl/gpio_csr_pkg.sv
// Shared constants and types for the GPIO CSR block.
package gpio_csr_pkg;

  // Default parameter values for gpio_csr and gpio_sync.
  localparam int unsigned DefWidth      = 32;
  localparam int unsigned DefNIn        = 2;
  localparam int unsigned DefNOut       = 2;
  localparam logic [11:0] DefCsrBase    = 12'h000;
  localparam int unsigned DefSyncStages = 2;

  // PEND and MASK offsets relative to the first offset past the last output channel.
  localparam int unsigned PendRelOff = 0;
  localparam int unsigned MaskRelOff = 1;

  // Register class selected by a CSR offset.
  typedef enum logic [2:0] {
    RegNone,
    RegIn,
    RegOut,
    RegPend,
    RegMask
  } reg_sel_e;

  // Offset of an address from the block base; wraps modulo the 12-bit CSR space.
  function automatic logic [11:0] csr_offset(logic [11:0] addr, logic [11:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for one asynchronous GPIO input channel.
module gpio_sync
  import gpio_csr_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gpio_sync: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_csr.sv
// GPIO block with CSR access: synchronised inputs, registered outputs,
// change-detect pending bits with mask and a level interrupt.
module gpio_csr
  import gpio_csr_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned N_IN        = DefNIn,
  parameter int unsigned N_OUT       = DefNOut,
  parameter logic [11:0] CSR_BASE    = DefCsrBase,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [11:0]                 csr_addr,
  input  logic                        csr_re,
  input  logic                        csr_we,
  input  logic [WIDTH-1:0]            csr_wdata,
  output logic [WIDTH-1:0]            csr_rdata,
  output logic                        csr_rvalid,
  output logic                        csr_err,
  input  logic [N_IN-1:0][WIDTH-1:0]  gpio_in,
  output logic [N_OUT-1:0][WIDTH-1:0] gpio_out,
  output logic                        irq
);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("gpio_csr: WIDTH must be at least 1");
  end
  if (N_IN < 1 || N_IN > WIDTH) begin : g_bad_n_in
    $error("gpio_csr: N_IN must be in 1..WIDTH");
  end
  if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
    $error("gpio_csr: N_OUT must be in 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gpio_csr: SYNC_STAGES must be in 2..4");
  end

  localparam logic [11:0] OutLo    = 12'(N_IN);
  localparam logic [11:0] OutHi    = 12'(N_IN + N_OUT);
  localparam logic [11:0] PendOff  = 12'(N_IN + N_OUT + PendRelOff);
  localparam logic [11:0] MaskOff  = 12'(N_IN + N_OUT + MaskRelOff);
  // Detection arms this many cycles after reset release, once synchronisers
  // and previous-value flops hold real input data.
  localparam int unsigned ArmCount = SYNC_STAGES + 1;
  localparam int unsigned CntW     = $clog2(ArmCount + 1);

  logic [N_IN-1:0][WIDTH-1:0]  sync_in;
  logic [N_IN-1:0][WIDTH-1:0]  prev_q;
  logic [CntW-1:0]             arm_cnt_q, arm_cnt_d;
  logic [N_IN-1:0]             pend_q, pend_d;
  logic [N_IN-1:0]             mask_q, mask_d;
  logic [N_OUT-1:0][WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0]            rdata_q, rdata_d;
  logic                        rvalid_q, err_q, irq_q;

  logic [11:0]     off;
  reg_sel_e        sel;
  logic [WIDTH-1:0] rd_val;
  logic            acc_err;
  logic            armed;
  logic [N_IN-1:0] pend_set, pend_clr;

  for (genvar i = 0; i < N_IN; i++) begin : g_sync
    gpio_sync #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (gpio_in[i]),
      .q_o  (sync_in[i])
    );
  end

  // Decode the access offset into a register class.
  always_comb begin
    off = csr_offset(csr_addr, CSR_BASE);
    if (off < OutLo) begin
      sel = RegIn;
    end else if (off < OutHi) begin
      sel = RegOut;
    end else if (off == PendOff) begin
      sel = RegPend;
    end else if (off == MaskOff) begin
      sel = RegMask;
    end else begin
      sel = RegNone;
    end
  end

  // Read mux over pre-write state; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    case (sel)
      RegIn: begin
        for (int unsigned i = 0; i < N_IN; i++) begin
          if (off == 12'(i)) rd_val = sync_in[i];
        end
      end
      RegOut: begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
          if (off == 12'(N_IN + j)) rd_val = out_q[j];
        end
      end
      RegPend: rd_val = WIDTH'(pend_q);
      RegMask: rd_val = WIDTH'(mask_q);
      default: rd_val = '0;
    endcase
  end

  // Access errors: anything unmapped, or a write to a read-only input channel.
  assign acc_err = (csr_re | csr_we) & ((sel == RegNone) | (csr_we & (sel == RegIn)));

  assign armed = (arm_cnt_q == CntW'(ArmCount));

  // Next-state for outputs, PEND/MASK, read data and the arm counter.
  always_comb begin
    out_d = out_q;
    if (csr_we && sel == RegOut) begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
        if (off == 12'(N_IN + j)) out_d[j] = csr_wdata;
      end
    end

    for (int unsigned i = 0; i < N_IN; i++) begin
      pend_set[i] = armed & (sync_in[i] != prev_q[i]);
    end
    pend_clr = (csr_we && sel == RegPend) ? csr_wdata[N_IN-1:0] : '0;
    // A new event outranks a same-cycle clear.
    pend_d   = (pend_q & ~pend_clr) | pend_set;

    mask_d    = (csr_we && sel == RegMask) ? csr_wdata[N_IN-1:0] : mask_q;
    rdata_d   = csr_re ? rd_val : rdata_q;
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CntW'(1);
  end

  // All block state; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      arm_cnt_q <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      out_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= sync_in;
      arm_cnt_q <= arm_cnt_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      out_q     <= out_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= csr_re;
      err_q     <= acc_err;
      irq_q     <= |(pend_q & mask_q);
    end
  end

  assign csr_rdata  = rdata_q;
  assign csr_rvalid = rvalid_q;
  assign csr_err    = err_q;
  assign gpio_out   = out_q;
  assign irq        = irq_q;

endmodule

// File: doc/gpio_csr.md
GPIO_CSR -- requirements
Module: gpio_csr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each GPIO channel and CSR data bus.
REQ-002 SHALL have parameter N_IN, default 2, number of input channels, legal range 1..WIDTH.
REQ-003 SHALL have parameter N_OUT, default 2, number of output channels, legal range 1..16.
REQ-004 SHALL have parameter CSR_BASE, default 12'h000, CSR address of input channel 0.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..4.
REQ-006 SHALL have ports: clk  in  1  clock; one clock domain, all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have ports csr_addr in 12 (CSR address), csr_re in 1 (read strobe), csr_we in 1 (write strobe), csr_wdata in WIDTH (write data).
REQ-009 SHALL have ports csr_rdata out WIDTH (registered read data), csr_rvalid out 1 (read-data valid pulse), csr_err out 1 (access-error pulse).
REQ-010 SHALL have ports gpio_in in N_IN x WIDTH (asynchronous inputs), gpio_out out N_OUT x WIDTH (registered outputs), irq out 1 (level interrupt).

Function
REQ-011 SHALL decode offset o = csr_addr - CSR_BASE: o in 0..N_IN-1 reads input channel o; N_IN..N_IN+N_OUT-1 reads/writes output channel o-N_IN; N_IN+N_OUT is PEND; N_IN+N_OUT+1 is MASK; all else unmapped.
REQ-012 SHALL pass each gpio_in channel through SYNC_STAGES flops; reads of an input channel return the synchronised value.
REQ-013 SHALL return read data with latency exactly 1: csr_re at edge k -> csr_rdata and 1-cycle csr_rvalid after edge k; csr_rdata holds its value until the next read.
REQ-014 SHALL apply a write to an output register at the edge sampling csr_we; gpio_out reflects the value from that edge on.
REQ-015 SHALL, on simultaneous csr_re and csr_we to one address, return the pre-write value.
REQ-016 SHALL set PEND[i] when synchronised channel i differs from its value on the previous cycle, and only while detection is armed.
REQ-017 SHALL arm detection via a counter reaching SYNC_STAGES+1 cycles after reset deassertion; counter saturates; no PEND bit sets while disarmed.
REQ-018 SHALL clear PEND bits by write-1-to-clear; a set event in the same cycle as a clear of that bit wins (bit stays 1).
REQ-019 SHALL make MASK read/write; bits at and above N_IN in PEND and MASK read 0 and ignore writes.
REQ-020 SHALL drive irq as a flop of |(PEND & MASK): one cycle after the PEND/MASK change.
REQ-021 SHALL pulse csr_err one cycle after any access to an unmapped offset or any write to an input channel; such writes change no state; such reads return 0 with csr_rvalid.
REQ-022 SHALL treat csr_re/csr_we low as idle: csr_rvalid and csr_err low, csr_rdata held.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear gpio_out, csr_rdata, csr_rvalid, csr_err, irq, PEND, MASK, synchroniser and previous-value flops, and the arm counter.
REQ-024 SHALL, on reset asserted mid-access, discard the access: no rvalid, no err, no write after release.

Structure
REQ-025 SHALL place the PEND/MASK relative offsets (0, 1 past last output) and default parameter values in shared package gpio_csr_pkg.
REQ-026 SHALL implement the per-channel synchroniser as sub-module gpio_sync (parameters WIDTH, SYNC_STAGES), instantiated N_IN times.
REQ-027 SHALL reject illegal parameters at elaboration.

Verification
REQ-028 SHALL cover: reset release, gpio_in[0]=32'h5 held from reset -> no PEND bit set, irq stays 0 for 20 cycles.
REQ-029 SHALL cover: write 32'hDEADBEEF to CSR_BASE+2 -> gpio_out[0]=32'hDEADBEEF next cycle; read CSR_BASE+2 -> rdata 32'hDEADBEEF, rvalid 1 cycle later.
REQ-030 SHALL cover: MASK=2'b10, gpio_in[1] 0->1 -> PEND=2'b10 after SYNC_STAGES+1 cycles, irq 1 one cycle later; write PEND=2'b10 -> irq 0.
REQ-031 SHALL cover: W1C of PEND[0] in the same cycle as a new channel-0 change -> PEND[0] remains 1.
REQ-032 SHALL cover: read CSR_BASE+12'h7F0 -> rdata 0, rvalid and csr_err one-cycle pulse; write CSR_BASE+0 -> csr_err pulse, no state change.
REQ-033 SHALL cover: read and write 32'h1 same cycle to CSR_BASE+3 holding 32'h0 -> rdata 32'h0, later read 32'h1; rst_n low mid-read -> no rvalid.
